ysyx_24100005_ifu: RTL and testbench
====================================

YSYX_24100005_IFU -- requirements
Module: ysyx_24100005_ifu

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, meaning the PC, address and instruction width.
REQ-002 The block SHALL have parameter RESET_PC, default 32'h8000_0000, meaning the first fetch address after reset.
REQ-003 The block SHALL have parameter BUF_DEPTH, default 2, meaning instruction buffer entries (power of two, >=2).
REQ-004 The block SHALL have port clk  input  1  meaning the single clock, rising edge.
REQ-005 The block SHALL have port rst  input  1  meaning reset, asynchronous, active-low.
REQ-006 The block SHALL have port redirect_valid  input  1  meaning a jump/branch target is supplied this cycle.
REQ-007 The block SHALL have port redirect_pc  input  XLEN  meaning the new fetch PC.
REQ-008 The block SHALL have port mem_req_valid  output  1  meaning a fetch request is presented.
REQ-009 The block SHALL have port mem_req_ready  input  1  meaning memory accepts the request.
REQ-010 The block SHALL have port mem_req_addr  output  XLEN  meaning the fetch address.
REQ-011 The block SHALL have port mem_resp_valid  input  1  meaning read data returned.
REQ-012 The block SHALL have port mem_resp_data  input  XLEN  meaning the fetched instruction word.
REQ-013 The block SHALL have port inst_valid  output  1  meaning the buffer head holds an instruction.
REQ-014 The block SHALL have port inst_ready  input  1  meaning the decoder consumes the head.
REQ-015 The block SHALL have port inst  output  XLEN  meaning the head instruction.
REQ-016 The block SHALL have port inst_pc  output  XLEN  meaning the PC of the head instruction.

Function
REQ-017 The FSM SHALL have states IDLE, REQ and WAIT, with at most one request outstanding.
REQ-018 IDLE->REQ SHALL occur when buffer occupancy < BUF_DEPTH; otherwise the FSM SHALL stay in IDLE.
REQ-019 In REQ, mem_req_valid SHALL be 1 with mem_req_addr = fetch_pc, held stable until mem_req_ready; on handshake the FSM SHALL go to WAIT.
REQ-020 In WAIT, on mem_resp_valid the {data, pc} pair SHALL be pushed, fetch_pc SHALL advance by 4 (mod 2^XLEN), and the FSM SHALL go to REQ if space remains after the push, else IDLE.
REQ-021 Request-to-push latency SHALL be one cycle after mem_resp_valid; the pushed entry SHALL be visible at inst_valid the following cycle.
REQ-022 A pop SHALL occur when inst_valid && inst_ready; a simultaneous push and pop SHALL leave occupancy unchanged.
REQ-023 Redirect SHALL set fetch_pc = {redirect_pc[XLEN-1:2], 2'b00}, flush the buffer, and drop inst_valid the next cycle.
REQ-024 A redirect in WAIT SHALL set a discard flag; the next response SHALL be dropped, and the FSM SHALL then issue to the new fetch_pc.
REQ-025 A redirect in REQ before the handshake SHALL replace mem_req_addr the next cycle; a redirect in the handshake cycle SHALL follow REQ-024.
REQ-026 Redirect SHALL take priority over a same-cycle pop or push.
REQ-027 Buffer pointers SHALL wrap modulo BUF_DEPTH, with full/empty distinguished by an extra pointer bit.

Reset
REQ-028 While rst=0: FSM=IDLE, fetch_pc=RESET_PC, buffer empty, discard flag=0, mem_req_valid=0, inst_valid=0, inst=0, inst_pc=0.
REQ-029 Reset mid-transaction SHALL abandon the outstanding request; the first response after release SHALL be accepted only for a request issued after release.

Structure
REQ-030 Package ysyx_24100005_pkg SHALL hold the FSM state typedef and the default RESET_PC constant.
REQ-031 The buffer SHALL be sub-module ysyx_24100005_ifu_fifo, parametrised by width and depth.

Verification
REQ-032 Reset release, memory always ready, 1-cycle response -> requests at 0x80000000, 0x80000004, 0x80000008; inst_pc follows in order.
REQ-033 inst_ready=0, BUF_DEPTH=2 -> two entries buffered, then mem_req_valid stays 0 until a pop.
REQ-034 Redirect to 0x80000102 while in WAIT -> in-flight response discarded; next mem_req_addr=0x80000100.
REQ-035 Redirect and pop in the same cycle with buffer full -> buffer empty next cycle, no duplicate inst delivered.
REQ-036 fetch_pc=0xFFFFFFFC, XLEN=32 -> next request address 0x00000000.
REQ-037 rst asserted during WAIT -> all outputs at reset values asynchronously; after release, first request at RESET_PC.

Source files
------------

// File: rtl/ysyx_24100005_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_24100005_pkg
// Description : Shared types and constants for the instruction fetch unit.
//               Holds the fetch FSM state encoding and the default reset PC.
// Revision    : 1.0 - initial release
// ============================================================================
package ysyx_24100005_pkg;

  // Fetch FSM state encoding (explicit 2-bit width)
  typedef logic [1:0] ifu_state_t;

  localparam ifu_state_t C_ST_IDLE = 2'd0;  // waiting for buffer space
  localparam ifu_state_t C_ST_REQ  = 2'd1;  // request presented to memory
  localparam ifu_state_t C_ST_WAIT = 2'd2;  // request accepted, awaiting data

  // Default first fetch address after reset
  localparam logic [31:0] C_RESET_PC = 32'h8000_0000;

endpackage
`default_nettype wire

// File: rtl/ysyx_24100005_ifu_fifo.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_24100005_ifu_fifo
// Description : Instruction buffer. Synchronous FIFO with extra-bit pointers
//               so full and empty are distinguished without a separate count.
//               flush empties the buffer and overrides push/pop.
// Ports       : clk, rst (async active-low), flush, push, push_data, pop,
//               empty, count (occupancy), head_data (entry at read pointer)
// Revision    : 1.0 - initial release
// ============================================================================
module ysyx_24100005_ifu_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic [WIDTH-1:0]         head_data
);

  localparam int C_AW = $clog2(DEPTH);
  localparam logic [C_AW:0] C_ONE = (C_AW+1)'(1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [C_AW:0]    r_wr_ptr;
  logic [C_AW:0]    r_rd_ptr;
  logic             w_full;
  logic             w_do_push;
  logic             w_do_pop;

  // Same index with differing wrap bits means the writer is a lap ahead
  assign empty  = (r_wr_ptr == r_rd_ptr);
  assign w_full = (r_wr_ptr[C_AW] != r_rd_ptr[C_AW]) &&
                  (r_wr_ptr[C_AW-1:0] == r_rd_ptr[C_AW-1:0]);
  assign count  = r_wr_ptr - r_rd_ptr;

  assign w_do_pop  = pop && !empty;
  assign w_do_push = push && (!w_full || w_do_pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + C_ONE;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + C_ONE;
    end
  end

  // Storage needs no reset: entries are only observable while occupied
  always_ff @(posedge clk) begin
    if (w_do_push && !flush) r_mem[r_wr_ptr[C_AW-1:0]] <= push_data;
  end

  assign head_data = r_mem[r_rd_ptr[C_AW-1:0]];

endmodule
`default_nettype wire

// File: rtl/ysyx_24100005_ifu.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_24100005_ifu
// Description : Instruction fetch unit. Issues one fetch at a time to memory
//               (valid/ready request, valid-only response), buffers returned
//               {instruction, pc} pairs and presents them to the decoder.
//               A redirect re-aims fetch, flushes the buffer, and drops any
//               response still in flight.
// Ports       : clk, rst (async active-low)
//               redirect_valid/redirect_pc      - jump/branch target
//               mem_req_valid/ready/addr        - fetch request
//               mem_resp_valid/data             - fetch response
//               inst_valid/ready, inst, inst_pc - decoder side
// Revision    : 1.0 - initial release
// ============================================================================
module ysyx_24100005_ifu
  import ysyx_24100005_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = C_RESET_PC,
  parameter int              BUF_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic [XLEN-1:0] mem_req_addr,
  input  logic            mem_resp_valid,
  input  logic [XLEN-1:0] mem_resp_data,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc
);

  localparam int                C_CW      = $clog2(BUF_DEPTH) + 1;
  localparam logic [C_CW-1:0]   C_DEPTH   = C_CW'(BUF_DEPTH);
  localparam logic [C_CW:0]     C_DEPTH_X = (C_CW+1)'(BUF_DEPTH);
  localparam logic [XLEN-1:0]   C_STEP    = XLEN'(4);
  localparam logic [XLEN-1:0]   C_ALIGN   = ~XLEN'(3);

  ifu_state_t        r_state;
  ifu_state_t        w_state_nxt;
  logic [XLEN-1:0]   r_fetch_pc;
  logic              r_discard;

  logic              w_empty;
  logic [C_CW-1:0]   w_count;
  logic [2*XLEN-1:0] w_head;
  logic              w_pop;
  logic              w_push;
  logic              w_resp_in_wait;
  logic [C_CW:0]     w_count_after;
  logic              w_set_discard;

  assign w_resp_in_wait = (r_state == C_ST_WAIT) && mem_resp_valid;

  // A response is kept only if nothing has re-aimed fetch since it was issued
  assign w_push = w_resp_in_wait && !r_discard && !redirect_valid;
  assign w_pop  = inst_valid && inst_ready;

  // Occupancy after this cycle's push/pop decides whether to keep fetching
  assign w_count_after = {1'b0, w_count}
                       + {{C_CW{1'b0}}, w_push}
                       - {{C_CW{1'b0}}, w_pop};

  // Redirect while a request is (or becomes) outstanding without its data
  // arriving now: the eventual response belongs to the old path
  assign w_set_discard = redirect_valid &&
                         (((r_state == C_ST_WAIT) && !mem_resp_valid) ||
                          ((r_state == C_ST_REQ)  && mem_req_ready));

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      C_ST_IDLE: begin
        if (redirect_valid || (w_count < C_DEPTH)) w_state_nxt = C_ST_REQ;
      end
      C_ST_REQ: begin
        if (mem_req_ready) w_state_nxt = C_ST_WAIT;
      end
      C_ST_WAIT: begin
        if (mem_resp_valid) begin
          if (redirect_valid || r_discard)     w_state_nxt = C_ST_REQ;
          else if (w_count_after < C_DEPTH_X)  w_state_nxt = C_ST_REQ;
          else                                 w_state_nxt = C_ST_IDLE;
        end
      end
      default: w_state_nxt = C_ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= C_ST_IDLE;
      r_fetch_pc <= RESET_PC;
      r_discard  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;

      if (redirect_valid)  r_fetch_pc <= redirect_pc & C_ALIGN;
      else if (w_push)     r_fetch_pc <= r_fetch_pc + C_STEP;

      if (w_set_discard)        r_discard <= 1'b1;
      else if (w_resp_in_wait)  r_discard <= 1'b0;
    end
  end

  ysyx_24100005_ifu_fifo #(
    .WIDTH (2*XLEN),
    .DEPTH (BUF_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .push      (w_push),
    .push_data ({mem_resp_data, r_fetch_pc}),
    .pop       (w_pop),
    .empty     (w_empty),
    .count     (w_count),
    .head_data (w_head)
  );

  assign mem_req_valid = (r_state == C_ST_REQ);
  assign mem_req_addr  = r_fetch_pc;

  // Head is zeroed while empty so outputs read as zero under reset
  assign inst_valid = !w_empty;
  assign inst       = w_empty ? '0 : w_head[2*XLEN-1:XLEN];
  assign inst_pc    = w_empty ? '0 : w_head[XLEN-1:0];

endmodule
`default_nettype wire

// File: tb/tb_ysyx_24100005_ifu.sv
`default_nettype none
// ============================================================================
// Module      : tb_ysyx_24100005_ifu
// Description : Self-checking bench for the fetch unit. A bench-side memory
//               answers requests after a programmable latency; a queue-based
//               model of the delivered instruction stream is compared with
//               the DUT every cycle, and directed scenarios pin key values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ysyx_24100005_ifu;

  localparam int          XLEN   = 32;
  localparam int          DEPTH  = 2;
  localparam logic [31:0] RST_PC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;

  always #5 clk = ~clk;

  ysyx_24100005_ifu #(
    .XLEN      (XLEN),
    .RESET_PC  (RST_PC),
    .BUF_DEPTH (DEPTH)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_addr   (mem_req_addr),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_data  (mem_resp_data),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc)
  );

  int n_pass  = 0;
  int n_total = 0;

  // bench memory
  int          mem_lat  = 1;
  bit          mem_busy = 0;
  int          mem_cnt  = 0;
  logic [31:0] mem_addr;

  // model of the fetch stream
  logic [31:0] m_pc;
  bit          m_out;
  bit          m_disc;
  logic [31:0] mq_pc[$];

  // observation logs
  logic [31:0] hs_log[$];
  logic [31:0] pop_log[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic model_reset();
    m_pc   = RST_PC;
    m_out  = 0;
    m_disc = 0;
    mq_pc.delete();
  endtask

  // One clock cycle: compare, advance model, let the edge happen, run memory
  task automatic tick();
    bit          hs;
    bit          pop;
    logic [31:0] hs_addr;
    if (!rst) chk("req_valid_in_reset", mem_req_valid, 0);
    chk("inst_valid", inst_valid, mq_pc.size() > 0);
    if (mq_pc.size() > 0) begin
      chk("inst_pc", inst_pc, mq_pc[0]);
      chk("inst", inst, mem_word(mq_pc[0]));
    end
    hs      = rst && mem_req_valid && mem_req_ready;
    hs_addr = mem_req_addr;
    if (rst && mem_req_valid) begin
      chk("one_outstanding", m_out, 0);
      chk("req_addr", mem_req_addr, m_pc);
      chk("req_space", mq_pc.size() < DEPTH, 1);
    end
    if (hs) hs_log.push_back(hs_addr);
    if (rst && inst_valid && inst_ready) pop_log.push_back(inst_pc);
    pop = (mq_pc.size() > 0) && inst_ready;

    if (!rst) begin
      model_reset();
    end else if (redirect_valid) begin
      mq_pc.delete();
      m_pc = redirect_pc & 32'hFFFF_FFFC;
      if (hs) begin
        m_out = 1; m_disc = 1;
      end else if (m_out && mem_resp_valid) begin
        m_out = 0; m_disc = 0;
      end else if (m_out) begin
        m_disc = 1;
      end
    end else begin
      if (pop) void'(mq_pc.pop_front());
      if (m_out && mem_resp_valid) begin
        if (!m_disc) begin
          mq_pc.push_back(m_pc);
          m_pc = m_pc + 32'd4;
        end
        m_out = 0; m_disc = 0;
      end
      if (hs) m_out = 1;
    end

    @(posedge clk);
    #1;
    mem_resp_valid = 1'b0;
    if (hs) begin
      mem_busy = 1; mem_cnt = mem_lat; mem_addr = hs_addr;
    end
    if (mem_busy) begin
      mem_cnt--;
      if (mem_cnt == 0) begin
        mem_resp_valid = 1'b1;
        mem_resp_data  = mem_word(mem_addr);
        mem_busy       = 0;
      end
    end
    @(negedge clk);
  endtask

  task automatic wait_hs(input int n, input string name);
    int i = 0;
    while (hs_log.size() < n && i < 60) begin tick(); i++; end
    chk(name, hs_log.size() >= n, 1);
  endtask

  task automatic wait_pop(input int n, input string name);
    int i = 0;
    while (pop_log.size() < n && i < 60) begin tick(); i++; end
    chk(name, pop_log.size() >= n, 1);
  endtask

  task automatic do_redirect(input logic [31:0] pc);
    redirect_pc    = pc;
    redirect_valid = 1'b1;
    tick();
    redirect_valid = 1'b0;
  endtask

  initial begin
    int base;
    rst = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    mem_req_ready = 1'b1; mem_resp_valid = 1'b0; mem_resp_data = '0;
    inst_ready = 1'b0;
    model_reset();
    @(negedge clk);

    // reset values
    chk("rst_req_valid", mem_req_valid, 0);
    chk("rst_inst_valid", inst_valid, 0);
    chk("rst_inst", inst, 0);
    chk("rst_inst_pc", inst_pc, 0);
    tick(); tick();
    rst = 1'b1;

    // streaming from RESET_PC, memory always ready, 1-cycle response
    inst_ready = 1'b1;
    wait_hs(3, "stream_hs_timeout");
    if (hs_log.size() >= 3) begin
      chk("stream_req0", hs_log[0], 32'h8000_0000);
      chk("stream_req1", hs_log[1], 32'h8000_0004);
      chk("stream_req2", hs_log[2], 32'h8000_0008);
    end
    wait_pop(3, "stream_pop_timeout");
    if (pop_log.size() >= 3) begin
      chk("stream_pc0", pop_log[0], 32'h8000_0000);
      chk("stream_pc1", pop_log[1], 32'h8000_0004);
      chk("stream_pc2", pop_log[2], 32'h8000_0008);
    end

    // decoder stalled: buffer fills to two, then requests stop
    inst_ready = 1'b0;
    do_redirect(32'h8000_1000);
    for (int i = 0; i < 20; i++) tick();
    base = hs_log.size();
    for (int i = 0; i < 10; i++) tick();
    chk("full_no_new_req", hs_log.size(), base);
    chk("full_req_valid", mem_req_valid, 0);
    chk("full_inst_valid", inst_valid, 1);
    chk("full_head_pc", inst_pc, 32'h8000_1000);
    hs_log.delete();
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    wait_hs(1, "after_pop_hs_timeout");
    if (hs_log.size() >= 1) chk("after_pop_req", hs_log[0], 32'h8000_1008);

    // redirect and pop together with a full buffer
    for (int i = 0; i < 10; i++) tick();
    chk("refull_inst_valid", inst_valid, 1);
    inst_ready = 1'b1;
    do_redirect(32'h8000_2000);
    chk("flush_inst_valid", inst_valid, 0);
    pop_log.delete();
    wait_pop(1, "flush_pop_timeout");
    if (pop_log.size() >= 1) chk("flush_first_pc", pop_log[0], 32'h8000_2000);

    // redirect while waiting on a slow response
    mem_lat = 3;
    hs_log.delete();
    wait_hs(1, "wait_hs_timeout");
    do_redirect(32'h8000_0102);
    hs_log.delete();
    pop_log.delete();
    wait_hs(1, "discard_hs_timeout");
    if (hs_log.size() >= 1) chk("discard_next_req", hs_log[0], 32'h8000_0100);
    wait_pop(1, "discard_pop_timeout");
    if (pop_log.size() >= 1) chk("discard_first_pc", pop_log[0], 32'h8000_0100);

    // address wrap at the top of the space
    mem_lat = 1;
    do_redirect(32'hFFFF_FFFC);
    hs_log.delete();
    wait_hs(2, "wrap_hs_timeout");
    if (hs_log.size() >= 2) begin
      chk("wrap_req0", hs_log[0], 32'hFFFF_FFFC);
      chk("wrap_req1", hs_log[1], 32'h0000_0000);
    end

    // asynchronous reset while waiting; stale response arrives after release
    mem_lat = 3;
    hs_log.delete();
    wait_hs(1, "pre_reset_hs_timeout");
    tick();
    rst = 1'b0;
    #2;
    chk("async_req_valid", mem_req_valid, 0);
    chk("async_inst_valid", inst_valid, 0);
    chk("async_inst", inst, 0);
    chk("async_inst_pc", inst_pc, 0);
    tick();
    rst = 1'b1;
    hs_log.delete();
    pop_log.delete();
    wait_hs(1, "post_reset_hs_timeout");
    if (hs_log.size() >= 1) chk("post_reset_req", hs_log[0], RST_PC);
    wait_pop(1, "post_reset_pop_timeout");
    if (pop_log.size() >= 1) chk("post_reset_pc", pop_log[0], RST_PC);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
